// File: rtl/d_latch_bank_if.sv
// Bus bundle for d_latch_bank: producer data/gates in, latched data and close pulses out.
// The valid/cap_cnt status signals exist only when DLATCH_STATUS_EN is defined.
interface d_latch_bank_if #(
  parameter int LANES  = 4,
  parameter int LANE_W = 8
);
  logic [LANES*LANE_W-1:0] d;
  logic [LANES-1:0]        c;
  logic [LANES*LANE_W-1:0] q;
  logic [LANES*LANE_W-1:0] q_n;
  logic [LANES-1:0]        closed;
`ifdef DLATCH_STATUS_EN
  logic [LANES-1:0]        valid;
  logic [15:0]             cap_cnt;

  modport master (output d, c, input q, q_n, closed, valid, cap_cnt);
  modport slave  (input d, c, output q, q_n, closed, valid, cap_cnt);
`else
  modport master (output d, c, input q, q_n, closed);
  modport slave  (input d, c, output q, q_n, closed);
`endif
endinterface

// File: rtl/d_latch_bank.sv
// Synchronous stand-in for a bank of gated D latches: transparent while c[k]=1, holds otherwise.
// Optional status outputs (valid, cap_cnt) are built only when DLATCH_STATUS_EN is defined.
module d_latch_bank #(
  parameter int                      LANES   = 4,
  parameter int                      LANE_W  = 8,
  parameter logic [LANES*LANE_W-1:0] RST_VAL = '0
) (
  input logic           clk,
  input logic           rst,
  d_latch_bank_if.slave bus
);
  localparam int W = LANES * LANE_W;

  logic [W-1:0]     hold;
  logic [LANES-1:0] c_q;
  logic [LANES-1:0] closed_r;
  logic [W-1:0]     q_int;

  always_ff @(posedge clk) begin
    if (rst) begin
      hold     <= RST_VAL;
      c_q      <= '0;
      closed_r <= '0;
    end else begin
      for (int k = 0; k < LANES; k++) begin
        if (bus.c[k]) hold[k*LANE_W +: LANE_W] <= bus.d[k*LANE_W +: LANE_W];
      end
      c_q      <= bus.c;
      closed_r <= c_q & ~bus.c;
    end
  end

  // Open lanes pass d straight through so there is no latency while transparent.
  always_comb begin
    q_int = hold;
    if (rst) begin
      q_int = RST_VAL;
    end else begin
      for (int k = 0; k < LANES; k++) begin
        if (bus.c[k]) q_int[k*LANE_W +: LANE_W] = bus.d[k*LANE_W +: LANE_W];
      end
    end
  end

  assign bus.q      = q_int;
  assign bus.q_n    = ~q_int;
  assign bus.closed = closed_r;

`ifdef DLATCH_STATUS_EN
  logic [LANES-1:0] valid_r;
  logic [15:0]      cap_cnt_r;
  logic [15:0]      pop;
  logic [16:0]      cnt_sum;

  always_comb begin
    pop = '0;
    for (int k = 0; k < LANES; k++) pop = pop + 16'(bus.c[k]);
    cnt_sum = {1'b0, cap_cnt_r} + {1'b0, pop};
  end

  // Carry out of the 16-bit sum means the counter would wrap; pin it at all-ones instead.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r   <= '0;
      cap_cnt_r <= '0;
    end else begin
      valid_r   <= valid_r | bus.c;
      cap_cnt_r <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    end
  end

  assign bus.valid   = valid_r;
  assign bus.cap_cnt = cap_cnt_r;
`endif
endmodule

// File: tb/tb_d_latch_bank.sv
// Directed bench for d_latch_bank (LANES=4, LANE_W=8, RST_VAL=0); status checks run when
// DLATCH_STATUS_EN is defined.
module tb_d_latch_bank;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  d_latch_bank_if #(.LANES(4), .LANE_W(8)) bus ();

  d_latch_bank #(.LANES(4), .LANE_W(8), .RST_VAL(32'h0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    bus.d = 32'hFFFF_FFFF;
    bus.c = 4'b1111;
    tick();
    tick();
    checks++;
    if (bus.q !== 32'h0) begin
      errors++; $display("FAIL reset_q got %h exp %h", bus.q, 32'h0);
    end
    checks++;
    if (bus.q_n !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL reset_q_n got %h exp %h", bus.q_n, 32'hFFFF_FFFF);
    end
    checks++;
    if (bus.closed !== 4'b0000) begin
      errors++; $display("FAIL reset_closed got %b exp %b", bus.closed, 4'b0000);
    end
`ifdef DLATCH_STATUS_EN
    checks++;
    if (bus.valid !== 4'b0000) begin
      errors++; $display("FAIL reset_valid got %b exp %b", bus.valid, 4'b0000);
    end
    checks++;
    if (bus.cap_cnt !== 16'd0) begin
      errors++; $display("FAIL reset_cap_cnt got %0d exp %0d", bus.cap_cnt, 0);
    end
`endif
  endtask

  task automatic test_transparency();
    rst   = 1'b0;
    bus.c = 4'b0001;
    bus.d = 32'hFAB7_998B;
    #1;
    checks++;
    if (bus.q !== 32'h0000_008B) begin
      errors++; $display("FAIL transp_q got %h exp %h", bus.q, 32'h0000_008B);
    end
    checks++;
    if (bus.q_n !== 32'hFFFF_FF74) begin
      errors++; $display("FAIL transp_q_n got %h exp %h", bus.q_n, 32'hFFFF_FF74);
    end
    tick();
    checks++;
    if (bus.closed !== 4'b0000) begin
      errors++; $display("FAIL first_after_reset_closed got %b exp %b", bus.closed, 4'b0000);
    end
  endtask

  task automatic test_hold();
    bus.c = 4'b0000;
    bus.d = 32'h0000_0011;
    #1;
    checks++;
    if (bus.q !== 32'h0000_008B) begin
      errors++; $display("FAIL hold_q got %h exp %h", bus.q, 32'h0000_008B);
    end
    checks++;
    if (bus.closed !== 4'b0000) begin
      errors++; $display("FAIL hold_closed_early got %b exp %b", bus.closed, 4'b0000);
    end
    tick();
    checks++;
    if (bus.closed !== 4'b0001) begin
      errors++; $display("FAIL hold_closed_pulse got %b exp %b", bus.closed, 4'b0001);
    end
    bus.d = 32'hDEAD_BEEF;
    tick();
    checks++;
    if (bus.closed !== 4'b0000) begin
      errors++; $display("FAIL hold_closed_end got %b exp %b", bus.closed, 4'b0000);
    end
    checks++;
    if (bus.q !== 32'h0000_008B) begin
      errors++; $display("FAIL hold_q_late got %h exp %h", bus.q, 32'h0000_008B);
    end
  endtask

  task automatic test_lanes();
    bus.c = 4'b1010;
    bus.d = 32'h0403_0201;
    #1;
    checks++;
    if (bus.q !== 32'h0400_028B) begin
      errors++; $display("FAIL lanes_q got %h exp %h", bus.q, 32'h0400_028B);
    end
    tick();
    bus.c = 4'b0000;
    bus.d = 32'h0000_0000;
    #1;
    checks++;
    if (bus.q !== 32'h0400_028B) begin
      errors++; $display("FAIL lanes_hold_q got %h exp %h", bus.q, 32'h0400_028B);
    end
    tick();
    checks++;
    if (bus.closed !== 4'b1010) begin
      errors++; $display("FAIL lanes_closed got %b exp %b", bus.closed, 4'b1010);
    end
    checks++;
    if (bus.q_n !== 32'hFBFF_FD74) begin
      errors++; $display("FAIL lanes_q_n got %h exp %h", bus.q_n, 32'hFBFF_FD74);
    end
  endtask

  task automatic test_reset_mid();
    bus.c = 4'b1111;
    bus.d = 32'hAAAA_AAAA;
    rst   = 1'b1;
    #1;
    checks++;
    if (bus.q !== 32'h0) begin
      errors++; $display("FAIL rstmid_q got %h exp %h", bus.q, 32'h0);
    end
    checks++;
    if (bus.q_n !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL rstmid_q_n got %h exp %h", bus.q_n, 32'hFFFF_FFFF);
    end
    tick();
    checks++;
    if (bus.closed !== 4'b0000) begin
      errors++; $display("FAIL rstmid_closed got %b exp %b", bus.closed, 4'b0000);
    end
    rst   = 1'b0;
    bus.d = 32'h0504_0302;
    #1;
    checks++;
    if (bus.q !== 32'h0504_0302) begin
      errors++; $display("FAIL rstrel_q got %h exp %h", bus.q, 32'h0504_0302);
    end
    tick();
    bus.c = 4'b0000;
    bus.d = 32'h1111_1111;
    #1;
    checks++;
    if (bus.q !== 32'h0504_0302) begin
      errors++; $display("FAIL rstrel_hold_q got %h exp %h", bus.q, 32'h0504_0302);
    end
    tick();
    checks++;
    if (bus.closed !== 4'b1111) begin
      errors++; $display("FAIL rstrel_closed got %b exp %b", bus.closed, 4'b1111);
    end
    tick();
    checks++;
    if (bus.closed !== 4'b0000) begin
      errors++; $display("FAIL rstrel_closed_end got %b exp %b", bus.closed, 4'b0000);
    end
  endtask

  task automatic test_single_cycle();
    bus.c = 4'b0100;
    bus.d = 32'h0077_0000;
    tick();
    bus.c = 4'b0000;
    bus.d = 32'h0000_0000;
    #1;
    checks++;
    if (bus.q !== 32'h0577_0302) begin
      errors++; $display("FAIL single_q got %h exp %h", bus.q, 32'h0577_0302);
    end
    tick();
    checks++;
    if (bus.closed !== 4'b0100) begin
      errors++; $display("FAIL single_closed got %b exp %b", bus.closed, 4'b0100);
    end
  endtask

`ifdef DLATCH_STATUS_EN
  task automatic test_status();
    rst   = 1'b1;
    bus.c = 4'b0000;
    tick();
    rst   = 1'b0;
    bus.c = 4'b0011;
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (bus.cap_cnt !== 16'd10) begin
      errors++; $display("FAIL status_cap_cnt got %0d exp %0d", bus.cap_cnt, 10);
    end
    checks++;
    if (bus.valid !== 4'b0011) begin
      errors++; $display("FAIL status_valid got %b exp %b", bus.valid, 4'b0011);
    end
    bus.c = 4'b1111;
    for (int i = 0; i < 16400; i++) tick();
    checks++;
    if (bus.cap_cnt !== 16'hFFFF) begin
      errors++; $display("FAIL status_sat got %h exp %h", bus.cap_cnt, 16'hFFFF);
    end
    tick();
    tick();
    checks++;
    if (bus.cap_cnt !== 16'hFFFF) begin
      errors++; $display("FAIL status_sat_stay got %h exp %h", bus.cap_cnt, 16'hFFFF);
    end
    checks++;
    if (bus.valid !== 4'b1111) begin
      errors++; $display("FAIL status_valid_all got %b exp %b", bus.valid, 4'b1111);
    end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    bus.d  = '0;
    bus.c  = '0;
    test_reset();
    test_transparency();
    test_hold();
    test_lanes();
    test_reset_mid();
    test_single_cycle();
`ifdef DLATCH_STATUS_EN
    test_status();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
